rv32_store_unit: RTL and testbench
==================================

RV32_STORE_UNIT -- requirements
Module: rv32_store_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 2, number of store buffer entries.
REQ-002 SHALL have parameter: IO_BASE, 32'h8000_0000; addresses >= IO_BASE target IO, all others target data memory.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- st_valid_in  in  1  MEM-stage instruction valid.
- iw_in  in  32  instruction word.
- addr_in  in  32  ALU effective address.
- rs2_data_in  in  32  store source data.
- st_ready_out  out  1  buffer can accept; low means stall.
- mem_req_out, mem_ack_in  out/in  1  memory write handshake.
- mem_addr_out  out  32  word address, bits [1:0]=0.
- mem_wdata_out  out  32  lane-replicated data.
- mem_be_out  out  4  byte enables.
- io_req_out, io_ack_in, io_addr_out, io_wdata_out, io_be_out  same widths  IO write port.
- ld_check_valid_in  in  1  WB/MEM load probe valid.
- ld_check_addr_in  in  32  load probe address.
- ld_conflict_out  out  1  pending store overlaps the probed word.
- misalign_out  out  1  one-cycle pulse: dropped misaligned store.
- store_count_out  out  16  completed-store counter.

Function
REQ-004 SHALL accept a store only when st_valid_in=1, iw_in[6:0]=7'b0100011 and st_ready_out=1; all other cycles SHALL be ignored.
REQ-005 SHALL use funct3=iw_in[14:12]: 000 SB, 001 SH, 010 SW; any other funct3 SHALL be dropped silently.
REQ-006 SB SHALL produce wdata={4{rs2[7:0]}} and be=4'b0001<<addr[1:0].
REQ-007 SH SHALL produce wdata={2{rs2[15:0]}} and be=addr[1]?4'b1100:4'b0011.
REQ-008 SW SHALL produce wdata=rs2 and be=4'b1111.
REQ-009 SH with addr[0]=1, or SW with addr[1:0]!=0, SHALL not be enqueued, and misalign_out SHALL pulse the following cycle.
REQ-010 Accepted stores SHALL enter a FIFO of DEPTH entries holding {word addr, wdata, be, is_io}.
REQ-011 st_ready_out SHALL equal (count<DEPTH), registered-state based; no pass-through when full, even with a same-cycle ack.
REQ-012 The bus FSM SHALL have states IDLE, BUSY_MEM and BUSY_IO. IDLE goes to BUSY_MEM or BUSY_IO per head is_io when count>0. BUSY_x stays until x_ack_in=1. On ack it pops the head and goes to IDLE if the FIFO is then empty, else to the state of the new head.
REQ-013 In BUSY_x, x_req_out SHALL be 1 and x_addr/wdata/be SHALL reflect the head entry, stable until ack; the other port's req SHALL be 0.
REQ-014 Back-to-back entries SHALL allow req to stay high across the ack edge, with new head fields presented the cycle after ack.
REQ-015 Ack inputs SHALL be ignored when the corresponding req is low.
REQ-016 Enqueue and dequeue in the same cycle SHALL leave count unchanged, and FIFO pointers SHALL wrap modulo DEPTH.
REQ-017 ld_conflict_out SHALL be combinational: ld_check_valid_in & any valid entry with addr[31:2]==ld_check_addr_in[31:2]. A store being enqueued in the same cycle SHALL be excluded.
REQ-018 store_count_out SHALL increment by 1 on each ack pop and wrap from 16'hFFFF to 0.
REQ-019 Memory-port outputs SHALL be 0 when the port is not requesting.

Reset
REQ-020 Asserting reset SHALL immediately force FSM=IDLE, count=0, pointers=0, all req/be/addr/wdata outputs=0, misalign_out=0, store_count_out=0 and st_ready_out=1.
REQ-021 Reset mid-transaction SHALL discard all buffered stores; a later ack SHALL have no effect.

Structure
REQ-022 Shared package rv32_pkg SHALL hold opcode STORE=7'b0100011, funct3 constants SB/SH/SW, the store-entry struct and the bus FSM state enum.
REQ-023 The FIFO SHALL be a sub-module rv32_store_fifo (parameter DEPTH, push/pop/full/empty/count, entry visibility for the conflict compare).

Verification
REQ-024 SB with addr=0x0000_0103, rs2=0x1234_56AB, immediate ack -> mem_addr=0x100, be=1000, wdata=0xABABABAB, count_out=1.
REQ-025 SW to 0x8000_0010, io_ack delayed 3 cycles -> io_req high 4 cycles with fields stable, mem_req=0 throughout.
REQ-026 Three SW with no ack -> st_ready_out=0 after the second; after one ack, the third enqueues the next cycle.
REQ-027 SH to 0x0000_0201 -> no req, misalign_out pulses once; SW to 0x202 -> misalign_out pulses once.
REQ-028 Pending SW at 0x40 with probe 0x43 -> ld_conflict_out=1; probe 0x44 -> 0.
REQ-029 Reset asserted during BUSY_MEM with 2 entries -> req drops in the same cycle, the subsequent ack is ignored, count_out=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 store path: opcode/funct3 encodings,
// the buffered store entry and the bus write FSM states.
package rv32_pkg;

    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // One buffered store: word address, lane-replicated data, byte enables, target port
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        is_io;
    } store_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_MEM = 2'd1,
        ST_BUSY_IO  = 2'd2
    } bus_state_t;

endpackage

// File: rtl/rv32_store_fifo.sv
// Circular store buffer. Exposes the head entry, the is_io flag of the entry
// behind the head (so the bus FSM can chain back-to-back writes), and every
// slot's valid bit and word address for the load-conflict compare.
module rv32_store_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_in,
    input  store_entry_t        push_data_in,
    input  logic                pop_in,
    output store_entry_t        head_out,
    output logic                next_is_io_out,
    output logic                full_out,
    output logic                empty_out,
    output logic [CW-1:0]       count_out,
    output logic [DEPTH-1:0]    slot_valid_out,
    output logic [DEPTH*30-1:0] slot_waddr_out
);

    store_entry_t     r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_slot_vld;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign w_push = push_in && !full_out;
    assign w_pop  = pop_in && !empty_out;

    // Entry storage, written at the write pointer; no reset needed on data
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data_in;
    end

    // Pointer and occupancy bookkeeping; simultaneous push+pop keeps the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Per-slot valid bits; push and pop can never hit the same slot in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && r_wr_ptr == PW'(i))     r_slot_vld[i] <= 1'b1;
                else if (w_pop && r_rd_ptr == PW'(i)) r_slot_vld[i] <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_waddr_out[gi*30 +: 30] = r_mem[gi].waddr;
    end

    assign head_out       = r_mem[r_rd_ptr];
    assign next_is_io_out = r_mem[ptr_inc(r_rd_ptr)].is_io;
    assign full_out       = (r_count == CW'(DEPTH));
    assign empty_out      = (r_count == '0);
    assign count_out      = r_count;
    assign slot_valid_out = r_slot_vld;

endmodule

// File: rtl/rv32_store_unit.sv
// RV32 MEM-stage store unit: decodes SB/SH/SW, drops misaligned stores,
// buffers accepted stores and drains them to the memory or IO write port.
module rv32_store_unit
    import rv32_pkg::*;
#(
    parameter int          DEPTH   = 2,
    parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] rs2_data_in,
    output logic        st_ready_out,
    output logic        mem_req_out,
    input  logic        mem_ack_in,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [3:0]  mem_be_out,
    output logic        io_req_out,
    input  logic        io_ack_in,
    output logic [31:0] io_addr_out,
    output logic [31:0] io_wdata_out,
    output logic [3:0]  io_be_out,
    input  logic        ld_check_valid_in,
    input  logic [31:0] ld_check_addr_in,
    output logic        ld_conflict_out,
    output logic        misalign_out,
    output logic [15:0] store_count_out
);

    localparam int CW = $clog2(DEPTH + 1);

    bus_state_t       r_state;
    bus_state_t       w_state_next;
    logic             r_misalign;
    logic [15:0]      r_store_count;

    store_entry_t     w_entry;
    store_entry_t     w_head;
    logic             w_known;
    logic             w_misalign;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_next_is_io;
    logic [CW-1:0]    w_count;
    logic [DEPTH-1:0] w_slot_vld;
    logic [DEPTH*30-1:0] w_slot_waddr;
    logic             w_conflict;
    logic             w_unused;

    // Decode funct3 into lane-replicated data, byte enables and alignment
    always_comb begin
        w_entry       = '0;
        w_known       = 1'b0;
        w_misalign    = 1'b0;
        w_entry.waddr = addr_in[31:2];
        w_entry.is_io = (addr_in >= IO_BASE);
        case (iw_in[14:12])
            F3_SB: begin
                w_known       = 1'b1;
                w_entry.wdata = {4{rs2_data_in[7:0]}};
                w_entry.be    = 4'b0001 << addr_in[1:0];
            end
            F3_SH: begin
                w_known       = 1'b1;
                w_entry.wdata = {2{rs2_data_in[15:0]}};
                w_entry.be    = addr_in[1] ? 4'b1100 : 4'b0011;
                w_misalign    = addr_in[0];
            end
            F3_SW: begin
                w_known       = 1'b1;
                w_entry.wdata = rs2_data_in;
                w_entry.be    = 4'b1111;
                w_misalign    = (addr_in[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    assign st_ready_out = !w_full;
    assign w_accept     = st_valid_in && (iw_in[6:0] == OP_STORE) && st_ready_out;
    assign w_push       = w_accept && w_known && !w_misalign;
    assign w_pop        = (r_state == ST_BUSY_MEM && mem_ack_in) ||
                          (r_state == ST_BUSY_IO  && io_ack_in);

    rv32_store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_in        (w_push),
        .push_data_in   (w_entry),
        .pop_in         (w_pop),
        .head_out       (w_head),
        .next_is_io_out (w_next_is_io),
        .full_out       (w_full),
        .empty_out      (w_empty),
        .count_out      (w_count),
        .slot_valid_out (w_slot_vld),
        .slot_waddr_out (w_slot_waddr)
    );

    // Bus FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: on ack, follow the entry that becomes the head (or go idle)
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_next = w_head.is_io ? ST_BUSY_IO : ST_BUSY_MEM;
            end
            ST_BUSY_MEM, ST_BUSY_IO: begin
                if (w_pop) begin
                    if (w_count > CW'(1))
                        w_state_next = w_next_is_io ? ST_BUSY_IO : ST_BUSY_MEM;
                    else if (w_push)
                        w_state_next = w_entry.is_io ? ST_BUSY_IO : ST_BUSY_MEM;
                    else
                        w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Port outputs: only the active port presents the head, everything else is zero
    always_comb begin
        mem_req_out   = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        mem_be_out    = '0;
        io_req_out    = 1'b0;
        io_addr_out   = '0;
        io_wdata_out  = '0;
        io_be_out     = '0;
        case (r_state)
            ST_BUSY_MEM: begin
                mem_req_out   = 1'b1;
                mem_addr_out  = {w_head.waddr, 2'b00};
                mem_wdata_out = w_head.wdata;
                mem_be_out    = w_head.be;
            end
            ST_BUSY_IO: begin
                io_req_out    = 1'b1;
                io_addr_out   = {w_head.waddr, 2'b00};
                io_wdata_out  = w_head.wdata;
                io_be_out     = w_head.be;
            end
            default: ;
        endcase
    end

    // Misalign pulse and completed-store counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign    <= 1'b0;
            r_store_count <= '0;
        end else begin
            r_misalign <= w_accept && w_known && w_misalign;
            if (w_pop) r_store_count <= r_store_count + 16'd1;
        end
    end

    // Word-granular overlap between the load probe and already-buffered stores
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_vld[i] && (w_slot_waddr[i*30 +: 30] == ld_check_addr_in[31:2]))
                w_conflict = 1'b1;
        end
    end

    assign ld_conflict_out = ld_check_valid_in && w_conflict;
    assign misalign_out    = r_misalign;
    assign store_count_out = r_store_count;

    assign w_unused = ^{iw_in[31:15], iw_in[11:7], ld_check_addr_in[1:0]};

endmodule

// File: tb/tb_rv32_store_unit.sv
// Scoreboard bench for rv32_store_unit: stimulus pushes expected bus writes,
// a negedge monitor compares every requesting cycle and drives the acks.
module tb_rv32_store_unit;

    typedef struct packed {
        logic        io;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        st_valid_in;
    logic [31:0] iw_in;
    logic [31:0] addr_in;
    logic [31:0] rs2_data_in;
    logic        st_ready_out;
    logic        mem_req_out;
    logic        mem_ack_in;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  mem_be_out;
    logic        io_req_out;
    logic        io_ack_in;
    logic [31:0] io_addr_out;
    logic [31:0] io_wdata_out;
    logic [3:0]  io_be_out;
    logic        ld_check_valid_in;
    logic [31:0] ld_check_addr_in;
    logic        ld_conflict_out;
    logic        misalign_out;
    logic [15:0] store_count_out;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   ack_budget = 1000;
    int   ack_delay = 0;
    bit   stray_ack = 0;
    int   wait_cnt = 0;
    int   last_stalls = 0;
    int   io_high = 0;
    int   mem_high = 0;
    exp_t mon_e;

    rv32_store_unit #(.DEPTH(2), .IO_BASE(32'h8000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .st_valid_in       (st_valid_in),
        .iw_in             (iw_in),
        .addr_in           (addr_in),
        .rs2_data_in       (rs2_data_in),
        .st_ready_out      (st_ready_out),
        .mem_req_out       (mem_req_out),
        .mem_ack_in        (mem_ack_in),
        .mem_addr_out      (mem_addr_out),
        .mem_wdata_out     (mem_wdata_out),
        .mem_be_out        (mem_be_out),
        .io_req_out        (io_req_out),
        .io_ack_in         (io_ack_in),
        .io_addr_out       (io_addr_out),
        .io_wdata_out      (io_wdata_out),
        .io_be_out         (io_be_out),
        .ld_check_valid_in (ld_check_valid_in),
        .ld_check_addr_in  (ld_check_addr_in),
        .ld_conflict_out   (ld_conflict_out),
        .misalign_out      (misalign_out),
        .store_count_out   (store_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3);
        return {17'h00A5A, f3, 5'd7, op};
    endfunction

    // Present a store until accepted; expected bus write queued if it should be buffered
    task automatic store(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input bit push, input logic [31:0] eaddr,
                         input logic [31:0] ewd, input logic [3:0] ebe);
        exp_t e;
        st_valid_in = 1'b1;
        iw_in       = mk_iw(op, f3);
        addr_in     = addr;
        rs2_data_in = data;
        last_stalls = 0;
        while (!st_ready_out && last_stalls < 40) begin
            step();
            last_stalls++;
        end
        if (last_stalls >= 40) begin
            checks++;
            failures++;
            $display("FAIL store_accept_timeout: got ready=0 expected ready=1 within 40 cycles");
        end
        if (push) begin
            e.io = eaddr[31]; e.addr = eaddr; e.wdata = ewd; e.be = ebe;
            exp_q.push_back(e);
        end
        step();
        st_valid_in = 1'b0;
        iw_in       = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mem_req_out || io_req_out) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Monitor: compare the presented head against the scoreboard, then ack it
    initial begin : monitor
        mem_ack_in = 1'b0;
        io_ack_in  = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack_in = stray_ack;
            io_ack_in  = stray_ack;
            if (reset) begin
                wait_cnt = 0;
            end else if (mem_req_out || io_req_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got mem=%0b io=%0b addr=0x%08h expected no request",
                             mem_req_out, io_req_out, mem_req_out ? mem_addr_out : io_addr_out);
                end else begin
                    mon_e = exp_q[0];
                    chk("port_is_io", 32'(io_req_out), 32'(mon_e.io));
                    chk("other_req", 32'(mon_e.io ? mem_req_out : io_req_out), 32'd0);
                    chk("addr", mon_e.io ? io_addr_out : mem_addr_out, mon_e.addr);
                    chk("wdata", mon_e.io ? io_wdata_out : mem_wdata_out, mon_e.wdata);
                    chk("be", 32'(mon_e.io ? io_be_out : mem_be_out), 32'(mon_e.be));
                    chk("idle_port_fields",
                        mon_e.io ? (mem_addr_out | mem_wdata_out | 32'(mem_be_out))
                                 : (io_addr_out | io_wdata_out | 32'(io_be_out)), 32'd0);
                    if (ack_budget > 0 && wait_cnt >= ack_delay) begin
                        if (io_req_out) io_ack_in = 1'b1;
                        else            mem_ack_in = 1'b1;
                        ack_budget--;
                        wait_cnt = 0;
                        $display("ack %s addr=0x%08h wdata=0x%08h be=%04b",
                                 io_req_out ? "io " : "mem", mon_e.addr, mon_e.wdata, mon_e.be);
                        void'(exp_q.pop_front());
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                chk("idle_outputs_zero",
                    mem_addr_out | mem_wdata_out | io_addr_out | io_wdata_out |
                    32'(mem_be_out) | 32'(io_be_out), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1;
        st_valid_in = 1'b0; iw_in = '0; addr_in = '0; rs2_data_in = '0;
        ld_check_valid_in = 1'b0; ld_check_addr_in = '0;
        step();
        chk("reset_ready", 32'(st_ready_out), 32'd1);
        chk("reset_mem_req", 32'(mem_req_out), 32'd0);
        chk("reset_io_req", 32'(io_req_out), 32'd0);
        chk("reset_misalign", 32'(misalign_out), 32'd0);
        chk("reset_count", 32'(store_count_out), 32'd0);
        step();
        reset = 1'b0;
        step();

        // SB into the top byte lane, immediate ack
        store(7'h23, 3'b000, 32'h0000_0103, 32'h1234_56AB, 1, 32'h0000_0100, 32'hABAB_ABAB, 4'b1000);
        drain();
        chk("count_after_sb", 32'(store_count_out), 32'd1);

        // Half and byte lanes
        store(7'h23, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 1, 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100);
        chk("sh_aligned_no_misalign", 32'(misalign_out), 32'd0);
        store(7'h23, 3'b001, 32'h0000_0204, 32'hCAFE_1234, 1, 32'h0000_0204, 32'h1234_1234, 4'b0011);
        store(7'h23, 3'b000, 32'h0000_0301, 32'h0000_00C3, 1, 32'h0000_0300, 32'hC3C3_C3C3, 4'b0010);
        drain();
        chk("count_after_lanes", 32'(store_count_out), 32'd4);

        // IO write with ack delayed three cycles
        ack_delay = 3;
        store(7'h23, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
        io_high = 0; mem_high = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (io_req_out)  io_high++;
            if (mem_req_out) mem_high++;
        end
        chk("io_req_cycles", 32'(io_high), 32'd4);
        chk("mem_req_during_io", 32'(mem_high), 32'd0);
        ack_delay = 0;
        drain();
        chk("count_after_io", 32'(store_count_out), 32'd5);

        // Misaligned and ignored stores
        store(7'h23, 3'b001, 32'h0000_0201, 32'h1111_2222, 0, 32'h0, 32'h0, 4'h0);
        chk("sh_misalign_pulse", 32'(misalign_out), 32'd1);
        step();
        chk("sh_misalign_one_cycle", 32'(misalign_out), 32'd0);
        store(7'h23, 3'b010, 32'h0000_0202, 32'h3333_4444, 0, 32'h0, 32'h0, 4'h0);
        chk("sw_misalign_pulse", 32'(misalign_out), 32'd1);
        step();
        chk("sw_misalign_one_cycle", 32'(misalign_out), 32'd0);
        store(7'h23, 3'b011, 32'h0000_0101, 32'h5555_6666, 0, 32'h0, 32'h0, 4'h0);
        chk("bad_funct3_silent", 32'(misalign_out), 32'd0);
        store(7'h03, 3'b010, 32'h0000_0102, 32'h7777_8888, 0, 32'h0, 32'h0, 4'h0);
        chk("non_store_silent", 32'(misalign_out), 32'd0);
        repeat (3) step();
        chk("count_after_dropped", 32'(store_count_out), 32'd5);

        // Full buffer stalls; one ack lets the third store in the next cycle
        ack_budget = 0;
        store(7'h23, 3'b010, 32'h0000_0010, 32'hA0A0_0001, 1, 32'h0000_0010, 32'hA0A0_0001, 4'b1111);
        store(7'h23, 3'b010, 32'h0000_0014, 32'hA0A0_0002, 1, 32'h0000_0014, 32'hA0A0_0002, 4'b1111);
        chk("ready_low_when_full", 32'(st_ready_out), 32'd0);
        ack_budget = 1;
        store(7'h23, 3'b010, 32'h0000_0018, 32'hA0A0_0003, 1, 32'h0000_0018, 32'hA0A0_0003, 4'b1111);
        chk("third_store_stall_cycles", 32'(last_stalls), 32'd1);
        chk("ready_low_after_third", 32'(st_ready_out), 32'd0);
        ack_budget = 1000;
        drain();
        chk("count_after_full", 32'(store_count_out), 32'd8);

        // Back-to-back memory then IO entries
        ack_budget = 0;
        store(7'h23, 3'b010, 32'h0000_0020, 32'h0102_0304, 1, 32'h0000_0020, 32'h0102_0304, 4'b1111);
        store(7'h23, 3'b010, 32'h8000_0020, 32'h0506_0708, 1, 32'h8000_0020, 32'h0506_0708, 4'b1111);
        ack_budget = 1000;
        drain();
        chk("count_after_mix", 32'(store_count_out), 32'd10);

        // Load conflict probe, including exclusion of a same-cycle enqueue
        ack_budget = 0;
        ld_check_valid_in = 1'b1;
        ld_check_addr_in  = 32'h0000_0040;
        st_valid_in = 1'b1;
        iw_in = mk_iw(7'h23, 3'b010);
        addr_in = 32'h0000_0040;
        rs2_data_in = 32'h4040_4040;
        #1;
        chk("conflict_same_cycle_excluded", 32'(ld_conflict_out), 32'd0);
        store(7'h23, 3'b010, 32'h0000_0040, 32'h4040_4040, 1, 32'h0000_0040, 32'h4040_4040, 4'b1111);
        ld_check_addr_in = 32'h0000_0043;
        #1;
        chk("conflict_same_word", 32'(ld_conflict_out), 32'd1);
        ld_check_addr_in = 32'h0000_0044;
        #1;
        chk("conflict_next_word", 32'(ld_conflict_out), 32'd0);
        ld_check_valid_in = 1'b0;
        ld_check_addr_in = 32'h0000_0040;
        #1;
        chk("conflict_probe_invalid", 32'(ld_conflict_out), 32'd0);
        ack_budget = 1000;
        drain();
        chk("count_after_conflict", 32'(store_count_out), 32'd11);

        // Acks with no request pending change nothing
        stray_ack = 1'b1;
        repeat (3) step();
        stray_ack = 1'b0;
        step();
        chk("stray_ack_ignored", 32'(store_count_out), 32'd11);

        // Reset during BUSY_MEM with two buffered entries
        ack_budget = 0;
        store(7'h23, 3'b010, 32'h0000_0300, 32'h9999_0000, 1, 32'h0000_0300, 32'h9999_0000, 4'b1111);
        store(7'h23, 3'b010, 32'h0000_0304, 32'h9999_0001, 1, 32'h0000_0304, 32'h9999_0001, 4'b1111);
        chk("busy_before_reset", 32'(mem_req_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_drops_req", 32'(mem_req_out), 32'd0);
        chk("reset_clears_fields", mem_addr_out | mem_wdata_out | 32'(mem_be_out), 32'd0);
        chk("reset_ready_high", 32'(st_ready_out), 32'd1);
        chk("reset_clears_count", 32'(store_count_out), 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        stray_ack = 1'b1;
        repeat (3) step();
        stray_ack = 1'b0;
        ack_budget = 1000;
        step();
        chk("post_reset_ack_ignored", 32'(store_count_out), 32'd0);
        chk("post_reset_no_req", 32'(mem_req_out | io_req_out), 32'd0);

        // Unit keeps working after reset
        store(7'h23, 3'b000, 32'h0000_0000, 32'h0000_00FF, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0001);
        drain();
        chk("count_after_recovery", 32'(store_count_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
